// File: rtl/dispatch_queue_pkg.sv
// dispatch_queue_pkg
// Shared types for the dispatch queue: instruction classes, queue entry layout,
// per-slot classification flags, a minimal core configuration record and the
// class-priority encode used when an encoding matches more than one class.
package dispatch_queue_pkg;

    typedef enum logic [2:0] {
        CLS_IEU,
        CLS_MDU,
        CLS_CRYPTO,
        CLS_FPU,
        CLS_MEM,
        CLS_PRIV
    } instr_class_t;

    typedef struct packed {
        logic [31:0]  instr;
        instr_class_t cls;
    } dq_entry_t;

    // Raw decoder output; several flags may be set for one encoding.
    typedef struct packed {
        logic mem;
        logic fpu;
        logic crypto;
        logic mdu;
        logic priv;
        logic ieu;
    } cls_flags_t;

    // Core configuration: extension enables that affect classification.
    typedef struct packed {
        logic m_en;
        logic f_en;
        logic zk_en;
    } cvw_t;

    localparam cvw_t CvwDefault = '{m_en: 1'b1, f_en: 1'b1, zk_en: 1'b1};

    // Priority Mem > FPU > Crypto > MDU > Priv > IEU; no match means illegal,
    // which goes to Priv so the trap path sees it.
    function automatic instr_class_t class_from_flags(cls_flags_t f);
        if (f.mem)         return CLS_MEM;
        else if (f.fpu)    return CLS_FPU;
        else if (f.crypto) return CLS_CRYPTO;
        else if (f.mdu)    return CLS_MDU;
        else if (f.priv)   return CLS_PRIV;
        else if (f.ieu)    return CLS_IEU;
        else               return CLS_PRIV;
    endfunction

    // Width of an issue-slot index; kept at least 1 bit for ISSUE_WIDTH=1.
    function automatic int unsigned order_w(int unsigned iw);
        return (iw > 1) ? $clog2(iw) : 1;
    endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// dispatch_queue_if
// Bundles the decode-side enqueue port, the flush request and the per-unit
// valid/ready issue ports of the dispatch queue.
//   slave  : the queue (consumes instructions/Ready, drives Valid/Instr/Order)
//   master : decode + execution units
interface dispatch_queue_if
    import dispatch_queue_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned NUM_IEU     = 2
);
    localparam int unsigned OrderW = order_w(ISSUE_WIDTH);
    localparam int unsigned CountW = $clog2(DEPTH + 1);

    logic                        flush;
    logic [FETCH_WIDTH-1:0]      instr_valid_d;
    logic [32*FETCH_WIDTH-1:0]   instr_d;
    logic                        enq_ready;
    logic [CountW-1:0]           count;

    logic [NUM_IEU-1:0]          ieu_ready;
    logic [NUM_IEU-1:0]          ieu_valid;
    logic [32*NUM_IEU-1:0]       ieu_instr;
    logic [OrderW*NUM_IEU-1:0]   ieu_order;

    logic mdu_ready, mdu_valid;
    logic cry_ready, cry_valid;
    logic fpu_ready, fpu_valid;
    logic mem_ready, mem_valid;
    logic priv_ready, priv_valid;
    logic [31:0] mdu_instr, cry_instr, fpu_instr, mem_instr, priv_instr;
    logic [OrderW-1:0] mdu_order, cry_order, fpu_order, mem_order, priv_order;

    modport slave (
        input  flush, instr_valid_d, instr_d,
        input  ieu_ready, mdu_ready, cry_ready, fpu_ready, mem_ready, priv_ready,
        output enq_ready, count,
        output ieu_valid, ieu_instr, ieu_order,
        output mdu_valid, mdu_instr, mdu_order,
        output cry_valid, cry_instr, cry_order,
        output fpu_valid, fpu_instr, fpu_order,
        output mem_valid, mem_instr, mem_order,
        output priv_valid, priv_instr, priv_order
    );

    modport master (
        output flush, instr_valid_d, instr_d,
        output ieu_ready, mdu_ready, cry_ready, fpu_ready, mem_ready, priv_ready,
        input  enq_ready, count,
        input  ieu_valid, ieu_instr, ieu_order,
        input  mdu_valid, mdu_instr, mdu_order,
        input  cry_valid, cry_instr, cry_order,
        input  fpu_valid, fpu_instr, fpu_order,
        input  mem_valid, mem_instr, mem_order,
        input  priv_valid, priv_instr, priv_order
    );

endinterface

// File: rtl/dispatch_queue_type_decoder.sv
// dispatch_queue_type_decoder (typeDecoder)
// Purely combinational RV32 opcode classifier for one enqueue slot.
//   i_instr : 32-bit instruction
//   o_flags : one flag per class the encoding matches (may overlap, may be empty)
module dispatch_queue_type_decoder
    import dispatch_queue_pkg::*;
#(
    parameter cvw_t P = CvwDefault
) (
    input  logic [31:0] i_instr,
    output cls_flags_t  o_flags
);
    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_is_op;
    logic       w_is_imm;
    logic       w_unused_bits;

    assign w_op     = i_instr[6:0];
    assign w_f3     = i_instr[14:12];
    assign w_f7     = i_instr[31:25];
    assign w_is_op  = (w_op == 7'b0110011);
    assign w_is_imm = (w_op == 7'b0010011);
    // Register specifiers never affect the class.
    assign w_unused_bits = ^{i_instr[11:7], i_instr[19:15], i_instr[21:20]};

    always_comb begin
        o_flags = '0;

        o_flags.mem = ((w_op == 7'b0000011) && (w_f3 inside {3'b000, 3'b001, 3'b010,
                                                               3'b100, 3'b101}))
                   || ((w_op == 7'b0100011) && (w_f3 inside {3'b000, 3'b001, 3'b010}))
                   || ((w_op == 7'b0101111) && (w_f3 == 3'b010))
                   || (P.f_en && (w_op inside {7'b0000111, 7'b0100111}) && (w_f3 == 3'b010));

        o_flags.fpu = P.f_en && (w_op inside {7'b1010011, 7'b1000011, 7'b1000111,
                                              7'b1001011, 7'b1001111});

        // aes32{e,d}s{,m}i and sha256{sum,sig}{0,1}
        o_flags.crypto = P.zk_en
            && ((w_is_op && (w_f3 == 3'b000)
                 && (i_instr[29:25] inside {5'b10001, 5'b10011, 5'b10101, 5'b10111}))
             || (w_is_imm && (w_f3 == 3'b001) && (i_instr[31:22] == 10'b0001000000)));

        o_flags.mdu = P.m_en && w_is_op && (w_f7 == 7'b0000001);

        o_flags.priv = (w_op == 7'b1110011) || (w_op == 7'b0001111);

        o_flags.ieu = (w_is_op && ((w_f7 == 7'b0000000)
                                   || ((w_f7 == 7'b0100000) && (w_f3 inside {3'b000, 3'b101}))))
                   || (w_is_imm && ((w_f3 == 3'b001) ? (w_f7 == 7'b0000000) :
                                    (w_f3 == 3'b101) ? (w_f7 inside {7'b0000000, 7'b0100000}) :
                                    1'b1))
                   || (w_op == 7'b0110111) || (w_op == 7'b0010111) || (w_op == 7'b1101111)
                   || ((w_op == 7'b1100111) && (w_f3 == 3'b000))
                   || ((w_op == 7'b1100011) && !(w_f3 inside {3'b010, 3'b011}));
    end

endmodule

// File: rtl/dispatch_queue.sv
// dispatch_queue
// In-order DEPTH-entry issue buffer. Classifies up to FETCH_WIDTH instructions
// per cycle at enqueue and issues up to ISSUE_WIDTH oldest entries per cycle to
// the IEU lanes and the MDU/Crypto/FPU/Mem/Priv ports.
//   i_clk   : clock, all state on the rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : enqueue port, flush, per-unit valid/ready/instr/order (slave side)
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter cvw_t        P           = CvwDefault,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned NUM_IEU     = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    dispatch_queue_if.slave bus
);
    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CountW = $clog2(DEPTH + 1);
    localparam int unsigned OrderW = order_w(ISSUE_WIDTH);
    localparam int unsigned Lane1  = (NUM_IEU > 1) ? 1 : 0;

    dq_entry_t         r_mem [DEPTH];
    logic [PtrW-1:0]   r_head, r_tail;
    logic [CountW-1:0] r_count;

    cls_flags_t        w_flags [FETCH_WIDTH];
    dq_entry_t         w_new   [FETCH_WIDTH];
    logic              w_enq_ok;
    logic [CountW-1:0] w_enq_n, w_issue_n;

    // Enqueue side: classification per slot.
    for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_dec
        dispatch_queue_type_decoder #(.P(P)) u_type_decoder (
            .i_instr (bus.instr_d[32*k +: 32]),
            .o_flags (w_flags[k])
        );
        assign w_new[k].instr = bus.instr_d[32*k +: 32];
        assign w_new[k].cls   = class_from_flags(w_flags[k]);
    end

    // Admission depends on registered Count only, never on same-cycle issue.
    assign bus.enq_ready = (r_count <= CountW'(DEPTH - FETCH_WIDTH));
    assign bus.count     = r_count;
    assign w_enq_ok      = bus.enq_ready && !bus.flush;

    always_comb begin
        w_enq_n = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (w_enq_ok && bus.instr_valid_d[k]) w_enq_n = w_enq_n + CountW'(1);
        end
    end

    // Issue allocator: scan oldest-first, stop at the first entry that cannot go.
    logic [PtrW-1:0] w_idx;
    dq_entry_t       w_ent;
    logic            w_go, w_stop;

    always_comb begin
        w_issue_n      = '0;
        w_stop         = 1'b0;
        w_idx          = '0;
        w_ent          = '0;
        w_go           = 1'b0;
        bus.ieu_valid  = '0;
        bus.ieu_instr  = '0;
        bus.ieu_order  = '0;
        bus.mdu_valid  = 1'b0;
        bus.mdu_instr  = '0;
        bus.mdu_order  = '0;
        bus.cry_valid  = 1'b0;
        bus.cry_instr  = '0;
        bus.cry_order  = '0;
        bus.fpu_valid  = 1'b0;
        bus.fpu_instr  = '0;
        bus.fpu_order  = '0;
        bus.mem_valid  = 1'b0;
        bus.mem_instr  = '0;
        bus.mem_order  = '0;
        bus.priv_valid = 1'b0;
        bus.priv_instr = '0;
        bus.priv_order = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            w_idx = r_head + PtrW'(k);
            w_ent = r_mem[w_idx];
            w_go  = 1'b0;
            if (!bus.flush && !w_stop && (CountW'(k) < r_count)) begin
                case (w_ent.cls)
                    CLS_IEU: begin
                        // Lowest free lane first; lane 1 shares its write port with Mem.
                        for (int l = 0; l < NUM_IEU; l++) begin
                            if (!w_go && bus.ieu_ready[l] && !bus.ieu_valid[l]
                                && !((l == 1) && bus.mem_valid)) begin
                                w_go                                = 1'b1;
                                bus.ieu_valid[l]                    = 1'b1;
                                bus.ieu_instr[32*l +: 32]           = w_ent.instr;
                                bus.ieu_order[OrderW*l +: OrderW]   = OrderW'(k);
                            end
                        end
                    end
                    CLS_MDU: if (bus.mdu_ready && !bus.mdu_valid) begin
                        w_go          = 1'b1;
                        bus.mdu_valid = 1'b1;
                        bus.mdu_instr = w_ent.instr;
                        bus.mdu_order = OrderW'(k);
                    end
                    CLS_CRYPTO: if (bus.cry_ready && !bus.cry_valid) begin
                        w_go          = 1'b1;
                        bus.cry_valid = 1'b1;
                        bus.cry_instr = w_ent.instr;
                        bus.cry_order = OrderW'(k);
                    end
                    CLS_FPU: if (bus.fpu_ready && !bus.fpu_valid) begin
                        w_go          = 1'b1;
                        bus.fpu_valid = 1'b1;
                        bus.fpu_instr = w_ent.instr;
                        bus.fpu_order = OrderW'(k);
                    end
                    CLS_MEM: if (bus.mem_ready && !bus.mem_valid
                                 && !((NUM_IEU > 1) && bus.ieu_valid[Lane1])) begin
                        w_go          = 1'b1;
                        bus.mem_valid = 1'b1;
                        bus.mem_instr = w_ent.instr;
                        bus.mem_order = OrderW'(k);
                    end
                    CLS_PRIV: if ((k == 0) && bus.priv_ready) begin
                        w_go           = 1'b1;
                        bus.priv_valid = 1'b1;
                        bus.priv_instr = w_ent.instr;
                        bus.priv_order = OrderW'(k);
                    end
                    default: ;
                endcase
            end
            if (w_go) w_issue_n = w_issue_n + CountW'(1);
            // Priv is serialising: nothing follows it in the same cycle.
            if (!w_go || (w_ent.cls == CLS_PRIV)) w_stop = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PtrW'(w_issue_n);
            r_tail  <= r_tail + PtrW'(w_enq_n);
            r_count <= r_count + w_enq_n - w_issue_n;
        end
    end

    // Storage needs no reset; only occupied entries are ever read.
    always_ff @(posedge i_clk) begin
        if (w_enq_ok) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (bus.instr_valid_d[k]) r_mem[r_tail + PtrW'(k)] <= w_new[k];
            end
        end
    end

endmodule

// File: tb/tb_dispatch_queue.sv
module tb_dispatch_queue;
    import dispatch_queue_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned FW    = 2;
    localparam int unsigned IW    = 2;
    localparam int unsigned NI    = 2;

    localparam logic [31:0] ADD   = 32'h003100B3;
    localparam logic [31:0] ADDI  = 32'h00108093;
    localparam logic [31:0] LW    = 32'h00012283;
    localparam logic [31:0] MUL   = 32'h023100B3;
    localparam logic [31:0] DIV   = 32'h023140B3;
    localparam logic [31:0] ECALL = 32'h00000073;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dispatch_queue_if #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .NUM_IEU(NI)) bus ();

    dispatch_queue #(
        .P           (CvwDefault),
        .DEPTH       (DEPTH),
        .FETCH_WIDTH (FW),
        .ISSUE_WIDTH (IW),
        .NUM_IEU     (NI)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] instr;
        int          unit;   // 0 IEU, 1 MDU, 2 Crypto, 3 FPU, 4 Mem, 5 Priv
    } exp_t;
    exp_t sb[$];

    function automatic int model_unit(logic [31:0] ins);
        case (ins[6:0])
            7'b0000011, 7'b0100011: return 4;
            7'b1110011:             return 5;
            7'b0110011:             return (ins[31:25] == 7'b0000001) ? 1 : 0;
            default:                return 0;
        endcase
    endfunction

    function automatic logic [31:0] mk_addi(int v);
        logic [11:0] imm;
        imm = v[11:0];
        return {imm, 5'd0, 3'b000, 5'd1, 7'b0010011};
    endfunction

    task automatic push(logic [31:0] ins);
        exp_t e;
        e.instr = ins;
        e.unit  = model_unit(ins);
        sb.push_back(e);
    endtask

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ready(logic v);
        bus.ieu_ready  = {NI{v}};
        bus.mdu_ready  = v;
        bus.cry_ready  = v;
        bus.fpu_ready  = v;
        bus.mem_ready  = v;
        bus.priv_ready = v;
    endtask

    task automatic drive(logic [1:0] v, logic [31:0] i0, logic [31:0] i1, bit accept);
        bus.instr_valid_d = v;
        bus.instr_d       = {i1, i0};
        if (accept && v[0]) push(i0);
        if (accept && v[1]) push(i1);
    endtask

    // Scoreboard monitor: every issue in a cycle is matched, in slot order,
    // against the oldest outstanding expected instruction.
    logic [31:0] m_ins [6];
    int          m_ord [6];
    int          m_unt [6];
    int          m_n, m_f;
    exp_t        m_e;

    always @(negedge clk) begin
        if (rst_n) begin
            m_n = 0;
            for (int l = 0; l < NI; l++) begin
                if (bus.ieu_valid[l]) begin
                    m_ins[m_n] = bus.ieu_instr[32*l +: 32];
                    m_ord[m_n] = int'(bus.ieu_order[l]);
                    m_unt[m_n] = 0;
                    m_n++;
                end
            end
            if (bus.mdu_valid)  begin m_ins[m_n] = bus.mdu_instr;  m_ord[m_n] = int'(bus.mdu_order);  m_unt[m_n] = 1; m_n++; end
            if (bus.cry_valid)  begin m_ins[m_n] = bus.cry_instr;  m_ord[m_n] = int'(bus.cry_order);  m_unt[m_n] = 2; m_n++; end
            if (bus.fpu_valid)  begin m_ins[m_n] = bus.fpu_instr;  m_ord[m_n] = int'(bus.fpu_order);  m_unt[m_n] = 3; m_n++; end
            if (bus.mem_valid)  begin m_ins[m_n] = bus.mem_instr;  m_ord[m_n] = int'(bus.mem_order);  m_unt[m_n] = 4; m_n++; end
            if (bus.priv_valid) begin m_ins[m_n] = bus.priv_instr; m_ord[m_n] = int'(bus.priv_order); m_unt[m_n] = 5; m_n++; end

            n_checks++;
            if ((!bus.mdu_valid && (bus.mdu_instr !== 32'd0 || bus.mdu_order !== '0))
                || (!bus.mem_valid && (bus.mem_instr !== 32'd0 || bus.mem_order !== '0))
                || (!bus.priv_valid && (bus.priv_instr !== 32'd0 || bus.priv_order !== '0))
                || (!bus.ieu_valid[0] && bus.ieu_instr[31:0] !== 32'd0)
                || (!bus.ieu_valid[1] && bus.ieu_instr[63:32] !== 32'd0)) begin
                n_fail++;
                $display("FAIL idle_port_zero: an invalid port carries nonzero instr/order at %0t, required 0", $time);
            end

            for (int o = 0; o < m_n; o++) begin
                m_f = -1;
                for (int j = 0; j < m_n; j++) if (m_ord[j] == o) m_f = j;
                n_checks++;
                if (m_f < 0) begin
                    n_fail++;
                    $display("FAIL issue_order: slot %0d missing among %0d issues at %0t", o, m_n, $time);
                end else if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL issue_unexpected: got instr %h unit %0d, required no issue", m_ins[m_f], m_unt[m_f]);
                end else begin
                    m_e = sb.pop_front();
                    if (m_ins[m_f] !== m_e.instr || m_unt[m_f] != m_e.unit) begin
                        n_fail++;
                        $display("FAIL issue_match: got instr %h unit %0d, required instr %h unit %0d",
                                 m_ins[m_f], m_unt[m_f], m_e.instr, m_e.unit);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if (bus.count !== 4'd0 || bus.enq_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_count: count %0d enq_ready %b, required 0 / 1", bus.count, bus.enq_ready);
        end
        n_checks++;
        if ({bus.ieu_valid, bus.mdu_valid, bus.cry_valid, bus.fpu_valid, bus.mem_valid, bus.priv_valid} !== 7'd0
            || bus.ieu_instr !== 64'd0 || bus.ieu_order !== 2'd0 || bus.mem_instr !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: ieu_valid %b mem_valid %b, required all zero", bus.ieu_valid, bus.mem_valid);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        set_ready(1'b1);
    endtask

    task automatic test_alu_pair();
        next();
        drive(2'b11, ADD, ADDI, 1);
        @(negedge clk); #1;
        n_checks++;
        if (bus.ieu_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL alu_no_bypass: ieu_valid %b, required 00", bus.ieu_valid);
        end
        next();
        drive(2'b00, 32'd0, 32'd0, 0);
        @(negedge clk); #1;
        n_checks++;
        if (bus.ieu_valid !== 2'b11 || bus.ieu_order !== 2'b10 || bus.count !== 4'd2) begin
            n_fail++;
            $display("FAIL alu_pair: ieu_valid %b order %b count %0d, required 11 / 10 / 2",
                     bus.ieu_valid, bus.ieu_order, bus.count);
        end
        next();
        n_checks++;
        if (bus.count !== 4'd0) begin
            n_fail++;
            $display("FAIL alu_pair_drain: count %0d, required 0", bus.count);
        end
    endtask

    task automatic test_mem_ieu();
        next();
        drive(2'b11, LW, ADD, 1);
        next();
        drive(2'b00, 32'd0, 32'd0, 0);
        @(negedge clk); #1;
        n_checks++;
        if (bus.mem_valid !== 1'b1 || bus.mem_order !== 1'b0 || bus.ieu_valid !== 2'b01 || bus.ieu_order !== 2'b01) begin
            n_fail++;
            $display("FAIL mem_ieu: mem_valid %b mem_order %b ieu_valid %b ieu_order %b, required 1 / 0 / 01 / 01",
                     bus.mem_valid, bus.mem_order, bus.ieu_valid, bus.ieu_order);
        end
        next();
    endtask

    task automatic test_lane_rule();
        bus.ieu_ready = 2'b10;
        next();
        drive(2'b11, ADD, LW, 1);
        next();
        drive(2'b00, 32'd0, 32'd0, 0);
        @(negedge clk); #1;
        n_checks++;
        if (bus.ieu_valid !== 2'b10 || bus.mem_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lane1_mem_block: ieu_valid %b mem_valid %b, required 10 / 0", bus.ieu_valid, bus.mem_valid);
        end
        next();
        n_checks++;
        if (bus.count !== 4'd1) begin
            n_fail++;
            $display("FAIL lane1_count: count %0d, required 1", bus.count);
        end
        @(negedge clk); #1;
        n_checks++;
        if (bus.mem_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL lane1_mem_late: mem_valid %b, required 1", bus.mem_valid);
        end
        next();
        bus.ieu_ready = 2'b11;
    endtask

    task automatic test_mdu();
        next();
        drive(2'b11, MUL, DIV, 1);
        next();
        drive(2'b00, 32'd0, 32'd0, 0);
        @(negedge clk); #1;
        n_checks++;
        if (bus.mdu_valid !== 1'b1 || bus.mdu_instr !== MUL) begin
            n_fail++;
            $display("FAIL mdu_first: mdu_valid %b instr %h, required 1 / %h", bus.mdu_valid, bus.mdu_instr, MUL);
        end
        next();
        n_checks++;
        if (bus.count !== 4'd1) begin
            n_fail++;
            $display("FAIL mdu_count: count %0d, required 1", bus.count);
        end
        @(negedge clk); #1;
        n_checks++;
        if (bus.mdu_instr !== DIV || bus.mdu_order !== 1'b0) begin
            n_fail++;
            $display("FAIL mdu_second: instr %h order %b, required %h / 0", bus.mdu_instr, bus.mdu_order, DIV);
        end
        next();
        n_checks++;
        if (bus.count !== 4'd0) begin
            n_fail++;
            $display("FAIL mdu_drain: count %0d, required 0", bus.count);
        end
    endtask

    task automatic test_priv();
        next();
        drive(2'b11, ADD, ECALL, 1);
        next();
        drive(2'b11, ADD, ADD, 1);
        @(negedge clk); #1;
        n_checks++;
        if (bus.ieu_valid !== 2'b01 || bus.priv_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL priv_hold: ieu_valid %b priv_valid %b, required 01 / 0", bus.ieu_valid, bus.priv_valid);
        end
        next();
        drive(2'b00, 32'd0, 32'd0, 0);
        n_checks++;
        if (bus.count !== 4'd3) begin
            n_fail++;
            $display("FAIL priv_count: count %0d, required 3", bus.count);
        end
        @(negedge clk); #1;
        n_checks++;
        if (bus.priv_valid !== 1'b1 || bus.priv_order !== 1'b0 || bus.ieu_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL priv_alone: priv_valid %b order %b ieu_valid %b, required 1 / 0 / 00",
                     bus.priv_valid, bus.priv_order, bus.ieu_valid);
        end
        next();
        @(negedge clk); #1;
        n_checks++;
        if (bus.ieu_valid !== 2'b11) begin
            n_fail++;
            $display("FAIL priv_after: ieu_valid %b, required 11", bus.ieu_valid);
        end
        next();
    endtask

    task automatic test_fill_wrap();
        set_ready(1'b0);
        for (int g = 0; g < 4; g++) begin
            next();
            n_checks++;
            if (bus.enq_ready !== 1'b1 || bus.count !== 4'(2 * g)) begin
                n_fail++;
                $display("FAIL fill_step: count %0d enq_ready %b, required %0d / 1", bus.count, bus.enq_ready, 2 * g);
            end
            drive(2'b11, mk_addi(2 * g), mk_addi(2 * g + 1), 1);
        end
        next();
        drive(2'b11, ADD, ADD, 0);
        n_checks++;
        if (bus.count !== 4'd8 || bus.enq_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: count %0d enq_ready %b, required 8 / 0", bus.count, bus.enq_ready);
        end
        next();
        drive(2'b00, 32'd0, 32'd0, 0);
        n_checks++;
        if (bus.count !== 4'd8) begin
            n_fail++;
            $display("FAIL fill_reject: count %0d, required 8", bus.count);
        end
        set_ready(1'b1);
        next();
        n_checks++;
        if (bus.count !== 4'd6 || bus.enq_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_edge: count %0d enq_ready %b, required 6 / 1", bus.count, bus.enq_ready);
        end
        drive(2'b11, mk_addi(100), mk_addi(101), 1);
        next();
        drive(2'b00, 32'd0, 32'd0, 0);
        n_checks++;
        if (bus.count !== 4'd6) begin
            n_fail++;
            $display("FAIL fill_simul: count %0d, required 6", bus.count);
        end
        for (int c = 0; c < 20 && bus.count != 0; c++) next();
        n_checks++;
        if (bus.count !== 4'd0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: count %0d pending %0d, required 0 / 0", bus.count, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            next();
            if (i >= 1) begin
                n_checks++;
                if (bus.count !== 4'd2) begin
                    n_fail++;
                    $display("FAIL b2b_count: step %0d count %0d, required 2", i, bus.count);
                end
            end
            drive(2'b11, mk_addi(200 + 2 * i), mk_addi(201 + 2 * i), 1);
        end
        next();
        drive(2'b00, 32'd0, 32'd0, 0);
        next();
        n_checks++;
        if (bus.count !== 4'd0) begin
            n_fail++;
            $display("FAIL b2b_drain: count %0d, required 0", bus.count);
        end
    endtask

    task automatic test_flush();
        set_ready(1'b0);
        next();
        drive(2'b11, ADD, ADD, 1);
        next();
        drive(2'b11, ADD, ADD, 1);
        next();
        drive(2'b01, ADD, 32'd0, 1);
        next();
        drive(2'b00, 32'd0, 32'd0, 0);
        n_checks++;
        if (bus.count !== 4'd5) begin
            n_fail++;
            $display("FAIL flush_setup: count %0d, required 5", bus.count);
        end
        bus.flush = 1'b1;
        set_ready(1'b1);
        drive(2'b11, ADD, ADD, 0);
        @(negedge clk); #1;
        n_checks++;
        if ({bus.ieu_valid, bus.mdu_valid, bus.mem_valid, bus.priv_valid} !== 5'd0) begin
            n_fail++;
            $display("FAIL flush_valid: ieu_valid %b, required all zero", bus.ieu_valid);
        end
        next();
        bus.flush = 1'b0;
        drive(2'b00, 32'd0, 32'd0, 0);
        sb.delete();
        n_checks++;
        if (bus.count !== 4'd0 || bus.enq_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_count: count %0d enq_ready %b, required 0 / 1", bus.count, bus.enq_ready);
        end
        @(negedge clk); #1;
        n_checks++;
        if (bus.ieu_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_empty: ieu_valid %b, required 00", bus.ieu_valid);
        end
    endtask

    task automatic test_async_reset();
        set_ready(1'b0);
        next();
        drive(2'b11, ADD, ADD, 1);
        next();
        drive(2'b00, 32'd0, 32'd0, 0);
        set_ready(1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.count !== 4'd0 || bus.enq_ready !== 1'b1 || bus.ieu_valid !== 2'b00 || bus.ieu_instr !== 64'd0) begin
            n_fail++;
            $display("FAIL async_reset: count %0d enq_ready %b ieu_valid %b, required 0 / 1 / 00",
                     bus.count, bus.enq_ready, bus.ieu_valid);
        end
        sb.delete();
        next();
        rst_n = 1'b1;
        next();
        drive(2'b11, ADD, MUL, 1);
        next();
        drive(2'b00, 32'd0, 32'd0, 0);
        next();
        n_checks++;
        if (bus.count !== 4'd0) begin
            n_fail++;
            $display("FAIL post_reset: count %0d, required 0", bus.count);
        end
    endtask

    initial begin
        bus.flush         = 1'b0;
        bus.instr_valid_d = '0;
        bus.instr_d       = '0;
        set_ready(1'b0);
        test_reset();
        test_alu_pair();
        test_mem_ieu();
        test_lane_rule();
        test_mdu();
        test_priv();
        test_fill_wrap();
        test_back_to_back();
        test_flush();
        test_async_reset();
        next();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d expected issues never seen, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

In-order, parametrised issue buffer between decode and the execution units of the superscalar core. Accepts up to FETCH_WIDTH decoded instructions per cycle into a DEPTH-entry circular queue, classifies each at enqueue, and issues up to ISSUE_WIDTH oldest instructions per cycle to per-unit valid/ready ports. Issue respects program order, unit availability and structural rules. A flush or reset empties the queue.

## Interface
- P: cvw_t, core configuration; sets extension enables for classification.
- DEPTH: 8; queue entries; power of 2, at least 2*FETCH_WIDTH.
- FETCH_WIDTH: 2; enqueue slots per cycle.
- ISSUE_WIDTH: 2; issue slots per cycle; ≤ FETCH_WIDTH.
- NUM_IEU: 2; integer ALU lanes.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = asserted).
- Flush  in  1  synchronous queue clear.
- InstrValidD  in  FETCH_WIDTH  per-slot valid; packed (slot k valid ⇒ slots <k valid).
- InstrD  in  32*FETCH_WIDTH  slot k at bits [32k+31:32k]; slot 0 oldest.
- EnqReady  out  1  queue can accept a full FETCH_WIDTH group this cycle.
- Count  out  $clog2(DEPTH+1)  occupied entries.
- IEUReady  in  NUM_IEU; IEUValid out NUM_IEU; IEUInstr out 32*NUM_IEU; IEUOrder out $clog2(ISSUE_WIDTH)*NUM_IEU.
- MDU/Crypto/FPU/Mem/Priv each: xReady in 1, xValid out 1, xInstr out 32, xOrder out $clog2(ISSUE_WIDTH) (issue-slot index of the instruction).

## Operation
- Classification at enqueue: exactly one class per instruction. Priority Mem > FPU > Crypto > MDU > Priv > IEU. Unrecognised or illegal encodings classify as Priv, so the trap path sees them. Class is stored with the instruction.
- Enqueue: when EnqReady=1, each valid slot is written at tail+k. tail advances by popcount(InstrValidD). When EnqReady=0, inputs are ignored; decode must hold them.
- EnqReady = (Count ≤ DEPTH−FETCH_WIDTH). Computed from registered Count only; same-cycle issue does not count.
- Issue scan over head+0 … head+ISSUE_WIDTH−1. Entry k issues iff all of the following hold:
  - it is occupied;
  - entries 0..k−1 issue this cycle (no younger-past-older issue);
  - a Ready unit of its class is still unallocated this cycle.
- IEU lanes are allocated lowest-index-first.
- Priv is serialising: it issues only from slot 0, and no other entry issues in the same cycle.
- Structural rule: IEU lane 1 is unavailable in any cycle a Mem instruction issues (shared write port).
- Each unit receives at most one instruction per cycle.
- xValid is asserted only when xReady=1, so every asserted Valid is a completed transfer. Units must drive Ready from a register.
- xInstr is 0 and xOrder is 0 when xValid=0.
- head advances by the number issued. Count_next = Count + enqueued − issued.
- Flush=1 has priority over everything: head=tail=Count=0, all xValid forced 0, enqueue ignored.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are determined from Count, not pointer equality.

## Timing
- Reset (asynchronous, reset=0): head=tail=Count=0. All xValid=0, all xInstr/xOrder=0, EnqReady=1. Queue contents are don't-care.
- Enqueue→issue latency: 1 cycle minimum. An instruction written at edge N may issue in cycle N+1. No bypass from InstrD to unit ports.
- Issue outputs are combinational from queue state and Ready. Head/Count update at the same edge as the transfer.
- Simultaneous enqueue and issue at Count=DEPTH−FETCH_WIDTH is legal. Count never exceeds DEPTH.
- Empty queue: all xValid=0 regardless of enqueue activity that cycle.
- Reset asserted mid-operation: state clears immediately (asynchronous). Outputs reach reset values before the next edge.

## Structure
- The shared package holds:
  - instr_class_t enum {CLS_IEU, CLS_MDU, CLS_CRYPTO, CLS_FPU, CLS_MEM, CLS_PRIV};
  - dq_entry_t struct {logic [31:0] instr; instr_class_t cls};
  - the class-priority ordering.
- Sub-module: typeDecoder, one instance per enqueue slot, produces class flags. A local priority encode maps the flags to instr_class_t.
- The remainder (storage array, pointers, issue allocator) is flat in dispatch_queue.

## Test plan
- Reset, then enqueue {ADD, ADDI} (FETCH_WIDTH=2), all Ready=1 → next cycle IEUValid=2'b11, IEUOrder lane0=0/lane1=1, Count returns to 0.
- Enqueue {LW, ADD}, all Ready=1 → MemValid=1 (Order 0), IEUValid=2'b01 (Order 1); lane 1 unused.
- Enqueue {MUL, DIV}, MDUReady=1 → cycle 1: MUL issues alone, Count=1; cycle 2: DIV issues, Count=0.
- Enqueue {ADD, ECALL, ADD, ADD} over two cycles → ADD issues; next cycle ECALL alone (PrivValid=1, Order 0); then both ADDs issue.
- Hold all Ready=0 and enqueue 4 groups at DEPTH=8 → Count=8, EnqReady=0 once Count>6. With Ready=1, drain order matches program order across pointer wrap.
- Count=5, Flush=1 with InstrValidD=2'b11 → next cycle Count=0, no Valid. Assert reset=0 mid-stream → outputs at reset values before the next edge.
